hyper_reg_init_seq: RTL and testbench

Register-bus initialisation sequencer that sits directly upstream of the HyperBus controller's register slave port. After reset (or on request), it waits a programmable power-up delay. It then replays a table of register writes (for example, timing, chip-select and `phys_in_use` configuration), optionally reads each one back to verify it, and reports done or a classified error. It replaces hand-driven register programming at bring-up, so the AXI path sees a configured controller.

---
 rtl/hyper_reg_init_seq.sv | 189 ++++++++++++++++++
 tb/tb_hyper_reg_init_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyper_reg_init_seq.sv
// rtl/hyper_reg_init_seq.sv - power-up register programming sequencer for the HyperBus register slave
module hyper_reg_init_seq #(
    parameter int RegAw         = 8,
    parameter int RegDw         = 32,
    parameter int NumEntries    = 4,
    parameter int StartDelay    = 16,
    parameter int TimeoutCycles = 64,
    parameter bit AutoStart     = 1'b1,
    localparam int IdxW         = (NumEntries > 1) ? $clog2(NumEntries) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [NumEntries*RegAw-1:0] tbl_addr_i,
    input  logic [NumEntries*RegDw-1:0] tbl_data_i,
    input  logic [NumEntries-1:0]       tbl_en_i,
    input  logic [NumEntries-1:0]       tbl_verify_i,
    output logic [RegAw-1:0]            reg_addr_o,
    output logic                        reg_write_o,
    output logic [RegDw-1:0]            reg_wdata_o,
    output logic [RegDw/8-1:0]          reg_wstrb_o,
    output logic                        reg_valid_o,
    input  logic [RegDw-1:0]            reg_rdata_i,
    input  logic                        reg_error_i,
    input  logic                        reg_ready_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o,
    output logic [1:0]                  err_code_o,
    output logic [IdxW-1:0]             err_idx_o
);

    localparam int DlyW = (StartDelay > 0) ? $clog2(StartDelay + 1) : 1;
    localparam int TmoW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [DlyW-1:0] DlyEnd  = DlyW'(StartDelay);
    localparam logic [TmoW-1:0] TmoLast = TmoW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELAY,
        ST_WRITE,
        ST_READ,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [DlyW-1:0]   dly_q, dly_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic [1:0]        code_d;
    logic [IdxW-1:0]   eidx_d;
    logic              load_d;
    logic              hs;
    logic              first_vld, next_vld;
    logic [IdxW-1:0]   first_idx, next_idx;
    logic [RegDw-1:0]  cur_data;
    logic              cur_verify;
    logic [RegAw-1:0]  ld_addr;
    logic [RegDw-1:0]  ld_data;

    assign reg_wstrb_o = '1;
    assign hs          = reg_valid_o && reg_ready_i;
    assign cur_data    = tbl_data_i[int'(idx_q) * RegDw +: RegDw];
    assign cur_verify  = tbl_verify_i[idx_q];
    assign ld_addr     = tbl_addr_i[int'(idx_d) * RegAw +: RegAw];
    assign ld_data     = tbl_data_i[int'(idx_d) * RegDw +: RegDw];

    // Lowest enabled entry overall, and lowest enabled entry above the current one.
    always_comb begin
        first_vld = 1'b0;
        first_idx = '0;
        next_vld  = 1'b0;
        next_idx  = '0;
        for (int k = NumEntries - 1; k >= 0; k--) begin
            if (tbl_en_i[k]) begin
                first_vld = 1'b1;
                first_idx = IdxW'(k);
            end
            if (tbl_en_i[k] && (k > int'(idx_q))) begin
                next_vld = 1'b1;
                next_idx = IdxW'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dly_d   = dly_q;
        tmo_d   = '0;
        code_d  = err_code_o;
        eidx_d  = err_idx_o;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_i) begin
                    code_d = 2'd0;
                    eidx_d = '0;
                    if (first_vld) begin
                        state_d = ST_WRITE;
                        idx_d   = first_idx;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DELAY: begin
                if (dly_q == DlyEnd) begin
                    dly_d = '0;
                    if (first_vld) begin
                        state_d = ST_WRITE;
                        idx_d   = first_idx;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            ST_WRITE, ST_READ: begin
                if (hs) begin
                    if (reg_error_i) begin
                        state_d = ST_ERROR;
                        code_d  = 2'd1;
                        eidx_d  = idx_q;
                    end else if ((state_q == ST_READ) && (reg_rdata_i != cur_data)) begin
                        state_d = ST_ERROR;
                        code_d  = 2'd2;
                        eidx_d  = idx_q;
                    end else if ((state_q == ST_WRITE) && cur_verify) begin
                        state_d = ST_READ;
                    end else if (next_vld) begin
                        state_d = ST_WRITE;
                        idx_d   = next_idx;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (TimeoutCycles > 0) begin
                    // The expiring cycle is the last one with valid high.
                    if (tmo_q == TmoLast) begin
                        state_d = ST_ERROR;
                        code_d  = 2'd3;
                        eidx_d  = idx_q;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        load_d = (state_d == ST_WRITE) && ((state_q != ST_WRITE) || hs);
    end

    // Outputs are decoded from the next state so they are plain flops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= AutoStart ? ST_DELAY : ST_IDLE;
            idx_q       <= '0;
            dly_q       <= '0;
            tmo_q       <= '0;
            reg_addr_o  <= '0;
            reg_wdata_o <= '0;
            reg_write_o <= 1'b0;
            reg_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            err_code_o  <= 2'd0;
            err_idx_o   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dly_q       <= dly_d;
            tmo_q       <= tmo_d;
            reg_write_o <= (state_d == ST_WRITE);
            reg_valid_o <= (state_d == ST_WRITE) || (state_d == ST_READ);
            busy_o      <= (state_d == ST_DELAY) || (state_d == ST_WRITE) || (state_d == ST_READ);
            done_o      <= (state_d == ST_DONE);
            err_o       <= (state_d == ST_ERROR);
            err_code_o  <= code_d;
            err_idx_o   <= eidx_d;
            if (load_d) begin
                reg_addr_o  <= ld_addr;
                reg_wdata_o <= ld_data;
            end
        end
    end

endmodule

// File: tb/tb_hyper_reg_init_seq.sv
// tb/tb_hyper_reg_init_seq.sv - self-checking bench for hyper_reg_init_seq
module tb_hyper_reg_init_seq;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 32;

    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] data;
    } acc_t;

    typedef struct {
        logic [N-1:0] en;
        logic [N-1:0] ver;
        int           corrupt;
        int           buserr;
        int           stall;
        logic         xdone;
        logic [1:0]   xcode;
        logic [1:0]   xidx;
        int           xn;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [N*AW-1:0] tbl_addr;
    logic [N*DW-1:0] tbl_data;
    logic [N-1:0]    tbl_en;
    logic [N-1:0]    tbl_ver;
    logic [AW-1:0]   reg_addr;
    logic            reg_write;
    logic [DW-1:0]   reg_wdata;
    logic [DW/8-1:0] reg_wstrb;
    logic            reg_valid;
    logic [DW-1:0]   reg_rdata = '0;
    logic            reg_error = 1'b0;
    logic            reg_ready = 1'b0;
    logic            busy, done, err;
    logic [1:0]      err_code;
    logic [1:0]      err_idx;

    int   n_checks = 0;
    int   n_fail   = 0;
    acc_t exp_q[$];
    acc_t log_q[$];
    logic [DW-1:0] mem [256];
    vec_t vecs[6];

    always #5 clk = ~clk;

    hyper_reg_init_seq dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .tbl_addr_i(tbl_addr), .tbl_data_i(tbl_data), .tbl_en_i(tbl_en), .tbl_verify_i(tbl_ver),
        .reg_addr_o(reg_addr), .reg_write_o(reg_write), .reg_wdata_o(reg_wdata), .reg_wstrb_o(reg_wstrb),
        .reg_valid_o(reg_valid), .reg_rdata_i(reg_rdata), .reg_error_i(reg_error), .reg_ready_i(reg_ready),
        .busy_o(busy), .done_o(done), .err_o(err), .err_code_o(err_code), .err_idx_o(err_idx)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_fixed_tbl();
        tbl_addr = {8'h30, 8'h20, 8'h10, 8'h00};
        tbl_data = {32'h4444_4444, 32'h0000_0000, 32'h2222_2222, 32'h1111_1111};
    endtask

    // Reference: walk enabled entries in order; each costs a write and an optional read-back.
    task automatic model(input logic [N-1:0] en, input logic [N-1:0] ver, input int corrupt,
                         input int buserr, output logic m_done, output logic [1:0] m_code,
                         output logic [1:0] m_idx);
        int   a;
        acc_t e;
        a = 0;
        exp_q.delete();
        m_done = 1'b1;
        m_code = 2'd0;
        m_idx  = 2'd0;
        for (int k = 0; k < N; k++) begin
            if (!en[k]) continue;
            e.addr = tbl_addr[k*AW +: AW];
            e.data = tbl_data[k*DW +: DW];
            e.wr   = 1'b1;
            exp_q.push_back(e);
            if (a == buserr) begin m_done = 1'b0; m_code = 2'd1; m_idx = 2'(k); return; end
            a++;
            if (ver[k]) begin
                e.wr = 1'b0;
                exp_q.push_back(e);
                if (a == buserr) begin m_done = 1'b0; m_code = 2'd1; m_idx = 2'(k); return; end
                a++;
                if (k == corrupt) begin m_done = 1'b0; m_code = 2'd2; m_idx = 2'(k); return; end
            end
        end
    endtask

    // Slave: stall each access, answer from a memory, optionally corrupt one read or flag an error.
    task automatic respond(input string name, input int stall, input int corrupt, input int buserr);
        int            w, nacc, ncyc;
        logic          hold, use_c;
        logic [AW-1:0] caddr;
        acc_t          h;
        w = 0; nacc = 0; ncyc = 0; hold = 1'b0;
        use_c = (corrupt >= 0) && (corrupt < N);
        caddr = use_c ? tbl_addr[corrupt*AW +: AW] : '0;
        log_q.delete();
        while (!(done || err)) begin
            if (ncyc >= 3000) begin
                n_checks++; n_fail++;
                $display("FAIL %s/finish: no done or err after %0d cycles", name, ncyc);
                break;
            end
            if (reg_valid) begin
                if (!hold) begin
                    hold = 1'b1; w = 0;
                    h.addr = reg_addr; h.wr = reg_write; h.data = reg_wdata;
                end else begin
                    check({name, "/stall_stable"}, {reg_addr, reg_write, reg_wdata}, {h.addr, h.wr, h.data});
                end
                if (w >= stall) begin
                    reg_ready = 1'b1;
                    reg_error = (nacc == buserr);
                    if (h.wr) mem[h.addr] = h.data;
                    reg_rdata = mem[h.addr] ^ ((use_c && h.addr == caddr) ? 32'h1 : 32'h0);
                    log_q.push_back(h);
                    nacc++;
                    hold = 1'b0;
                end else begin
                    reg_ready = 1'b0; reg_error = 1'b0; w++;
                end
            end else begin
                reg_ready = 1'b0; reg_error = 1'b0;
            end
            @(negedge clk);
            ncyc++;
        end
        reg_ready = 1'b0;
        reg_error = 1'b0;
    endtask

    task automatic run_case(input string name, input logic [N-1:0] en, input logic [N-1:0] ver,
                            input int corrupt, input int buserr, input int stall, input logic use_tbl,
                            input logic xdone, input logic [1:0] xcode, input logic [1:0] xidx, input int xn);
        logic       m_done;
        logic [1:0] m_code, m_idx;
        tbl_en  = en;
        tbl_ver = ver;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({name, "/start_clear"}, {done, err, err_code, err_idx}, {(en == '0), 5'b0});
        respond(name, stall, corrupt, buserr);
        model(en, ver, corrupt, buserr, m_done, m_code, m_idx);
        if (!use_tbl) begin
            xdone = m_done; xcode = m_code; xidx = m_idx; xn = exp_q.size();
        end
        check({name, "/status"}, {done, err, err_code}, {xdone, !xdone, xcode});
        if (!xdone) check({name, "/err_idx"}, err_idx, xidx);
        check({name, "/n_access"}, log_q.size(), xn);
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            check({name, "/acc_addr"}, log_q[i].addr, exp_q[i].addr);
            check({name, "/acc_wr"}, log_q[i].wr, exp_q[i].wr);
            if (exp_q[i].wr) check({name, "/acc_data"}, log_q[i].data, exp_q[i].data);
        end
    endtask

    // Reset, then auto-start with ready tied high; record first valid / done cycles and addresses.
    task automatic auto_run(input string name, input int xv, input int xd, input int xn);
        int            fv, fd;
        logic [AW-1:0] seen[$];
        logic [AW-1:0] want[$];
        fv = -1; fd = -1;
        reg_ready = 1'b1; reg_error = 1'b0; rst = 1'b1;
        repeat (2) @(negedge clk);
        check({name, "/rst_ctl"}, {reg_valid, reg_write, busy, done, err, err_code, err_idx}, 9'b0);
        check({name, "/rst_bus"}, {reg_addr, reg_wdata}, 40'b0);
        check({name, "/rst_wstrb"}, reg_wstrb, 4'hF);
        rst = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk); #1;
            if (reg_valid) begin
                if (fv < 0) fv = c;
                seen.push_back(reg_addr);
            end
            if (done && fd < 0) fd = c;
        end
        reg_ready = 1'b0;
        for (int k = 0; k < N; k++) if (tbl_en[k]) want.push_back(tbl_addr[k*AW +: AW]);
        check({name, "/first_valid"}, fv, xv);
        check({name, "/done_cycle"}, fd, xd);
        check({name, "/n_access"}, seen.size(), xn);
        for (int i = 0; i < seen.size() && i < want.size(); i++)
            check({name, "/addr_order"}, seen[i], want[i]);
    endtask

    initial begin
        int vcnt;
        vecs[0] = '{4'hF, 4'h4,  2, -1, 0, 1'b0, 2'd2, 2'd2, 4};
        vecs[1] = '{4'hA, 4'h0, -1, -1, 3, 1'b1, 2'd0, 2'd0, 2};
        vecs[2] = '{4'hF, 4'h0, -1,  0, 0, 1'b0, 2'd1, 2'd0, 1};
        vecs[3] = '{4'hF, 4'hF, -1, -1, 1, 1'b1, 2'd0, 2'd0, 8};
        vecs[4] = '{4'h0, 4'h0, -1, -1, 0, 1'b1, 2'd0, 2'd0, 0};
        vecs[5] = '{4'hC, 4'h8, -1,  2, 2, 1'b0, 2'd1, 2'd3, 3};

        set_fixed_tbl();
        tbl_en = 4'hF; tbl_ver = 4'h0;
        auto_run("auto", 17, 21, 4);

        for (int i = 0; i < 6; i++)
            run_case($sformatf("vec%0d", i), vecs[i].en, vecs[i].ver, vecs[i].corrupt, vecs[i].buserr,
                     vecs[i].stall, 1'b1, vecs[i].xdone, vecs[i].xcode, vecs[i].xidx, vecs[i].xn);

        // Silent slave: timeout after 64 valid cycles; a start pulse while busy changes nothing.
        tbl_en = 4'b0001; tbl_ver = 4'h0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        vcnt = 0;
        for (int c = 0; c < 200; c++) begin
            if (err) break;
            if (reg_valid) vcnt++;
            start = (c == 10);
            @(negedge clk);
        end
        start = 1'b0;
        check("timeout/valid_cycles", vcnt, 64);
        check("timeout/status", {err, err_code, err_idx}, {1'b1, 2'd3, 2'd0});
        check("timeout/bus_idle", {reg_valid, busy}, 2'b00);
        run_case("retry", 4'b0001, 4'h0, -1, -1, 0, 1'b1, 1'b1, 2'd0, 2'd0, 1);

        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < N; k++) begin
                tbl_addr[k*AW +: AW] = 8'(k * 16 + $urandom_range(0, 15));
                tbl_data[k*DW +: DW] = $urandom;
            end
            run_case($sformatf("rand%0d", i), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     $urandom_range(0, 5), $urandom_range(0, 9) - 2, $urandom_range(0, 3),
                     1'b0, 1'b0, 2'd0, 2'd0, 0);
        end

        // Reset during a stalled write drops valid at once, then the sequence replays from DELAY.
        set_fixed_tbl();
        tbl_en = 4'hF; tbl_ver = 4'h0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_mid/valid_before", reg_valid, 1'b1);
        #2 rst = 1'b1;
        #1 check("rst_mid/async_drop", {reg_valid, busy}, 2'b00);
        auto_run("rst_mid", 17, 21, 4);

        tbl_en = 4'h0;
        auto_run("none", -1, 17, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
